// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: forwarding-select encoding
// and the stall/hold FSM state type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    HOLD    = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hz_slot_pipe.sv
// Three-slot shadow of the EX/MEM/WB register-write information, used to
// detect load-use hazards and pick forwarding sources.
module hz_slot_pipe #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          dec_valid,
  input  logic          dec_regwr,
  input  logic          dec_mem2reg,
  input  logic [AW-1:0] dec_dst,
  output logic          ex_valid,
  output logic          ex_regwr,
  output logic          ex_mem2reg,
  output logic [AW-1:0] ex_dst,
  output logic          mem_valid,
  output logic          mem_regwr,
  output logic [AW-1:0] mem_dst,
  output logic          wb_valid,
  output logic          wb_regwr,
  output logic [AW-1:0] wb_dst
);

  logic          valid_p0, valid_p1, valid_p2;
  logic          regwr_p0, regwr_p1, regwr_p2;
  logic          mem2reg_p0;
  logic [AW-1:0] dst_p0, dst_p1, dst_p2;

  // Slot validity is control state and is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_p0 <= 1'b0;
      valid_p1 <= 1'b0;
      valid_p2 <= 1'b0;
    end else if (adv) begin
      valid_p0 <= dec_valid;
      valid_p1 <= valid_p0;
      valid_p2 <= valid_p1;
    end
  end

  // Payload is only meaningful under valid; the load flag matters only in EX.
  always_ff @(posedge clk) begin
    if (adv) begin
      regwr_p0   <= dec_regwr;
      mem2reg_p0 <= dec_mem2reg;
      dst_p0     <= dec_dst;
      regwr_p1   <= regwr_p0;
      dst_p1     <= dst_p0;
      regwr_p2   <= regwr_p1;
      dst_p2     <= dst_p1;
    end
  end

  assign ex_valid   = valid_p0;
  assign ex_regwr   = regwr_p0;
  assign ex_mem2reg = mem2reg_p0;
  assign ex_dst     = dst_p0;
  assign mem_valid  = valid_p1;
  assign mem_regwr  = regwr_p1;
  assign mem_dst    = dst_p1;
  assign wb_valid   = valid_p2;
  assign wb_regwr   = regwr_p2;
  assign wb_dst     = dst_p2;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait hold, taken-branch flush, load-use
// stall, jump flush, operand forwarding selects and saturating event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_regwr,
  input  logic          id_mem2reg,
  input  logic [AW-1:0] id_dst,
  input  logic          id_jump,
  input  logic          ex_br_taken,
  input  logic          mem_busy,
  output logic          pc_hold,
  output logic          ifid_hold,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  logic          ex_valid, ex_regwr, ex_mem2reg;
  logic [AW-1:0] ex_dst;
  logic          mem_valid, mem_regwr;
  logic [AW-1:0] mem_dst;
  logic          wb_valid, wb_regwr;
  logic [AW-1:0] wb_dst;

  hz_state_e state, pre_state, eff_state;
  logic      lu_raw, lu_act;

  function automatic logic slot_hit(input logic v, input logic wr,
                                    input logic [AW-1:0] dst, input logic [AW-1:0] src);
    return v && wr && (dst != '0) && (dst == src);
  endfunction

  // A matching load in EX blocks older slots: its value is not ready yet,
  // and the stall takes care of the operand on the next cycle.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [AW-1:0] src,
                                         input logic ex_hit, input logic ex_ld,
                                         input logic mem_hit, input logic wb_hit);
    if (!use_src || src == '0) return FWD_RF;
    if (ex_hit)                return ex_ld ? FWD_RF : FWD_EX;
    if (mem_hit)               return FWD_MEM;
    if (wb_hit)                return FWD_WB;
    return FWD_RF;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hz_slot_pipe #(.AW(AW)) u_slots (
    .clk         (clk),
    .rst_n       (rst_n),
    .adv         (!mem_busy),
    .dec_valid   (id_valid && !idex_bubble),
    .dec_regwr   (id_regwr),
    .dec_mem2reg (id_mem2reg),
    .dec_dst     (id_dst),
    .ex_valid    (ex_valid),
    .ex_regwr    (ex_regwr),
    .ex_mem2reg  (ex_mem2reg),
    .ex_dst      (ex_dst),
    .mem_valid   (mem_valid),
    .mem_regwr   (mem_regwr),
    .mem_dst     (mem_dst),
    .wb_valid    (wb_valid),
    .wb_regwr    (wb_regwr),
    .wb_dst      (wb_dst)
  );

  // While held, the cycle behaves as whatever state was interrupted.
  assign eff_state = (state == HOLD) ? pre_state : state;

  assign lu_raw = id_valid && ex_valid && ex_regwr && ex_mem2reg && (ex_dst != '0) &&
                  ((id_use_rs && id_rs == ex_dst) || (id_use_rt && id_rt == ex_dst));
  assign lu_act = rst_n && !mem_busy && !ex_br_taken && lu_raw && (eff_state != LDSTALL);

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    if (rst_n) begin
      fwd_a = fwd_sel(id_use_rs, id_rs,
                      slot_hit(ex_valid, ex_regwr, ex_dst, id_rs), ex_mem2reg,
                      slot_hit(mem_valid, mem_regwr, mem_dst, id_rs),
                      slot_hit(wb_valid, wb_regwr, wb_dst, id_rs));
      fwd_b = fwd_sel(id_use_rt, id_rt,
                      slot_hit(ex_valid, ex_regwr, ex_dst, id_rt), ex_mem2reg,
                      slot_hit(mem_valid, mem_regwr, mem_dst, id_rt),
                      slot_hit(wb_valid, wb_regwr, wb_dst, id_rt));
      if (mem_busy) begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
      end else if (ex_br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu_act) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pre_state <= RUN;
    end else if (mem_busy) begin
      if (state != HOLD) pre_state <= state;
      state <= HOLD;
    end else begin
      state <= lu_act ? LDSTALL : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lu_act)     stall_cnt <= sat_inc(stall_cnt);
      if (ifid_flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a narrow counter width lets the saturation
// cases be reached in a short run.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic          id_regwr = 1'b0, id_mem2reg = 1'b0, id_jump = 1'b0;
  logic          ex_br_taken = 1'b0, mem_busy = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic          pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwr(id_regwr),
    .id_mem2reg(id_mem2reg), .id_dst(id_dst), .id_jump(id_jump),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy), .pc_hold(pc_hold),
    .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic [3:0]    ctl;  // {pc_hold, ifid_hold, ifid_flush, idex_bubble}
    logic [3:0]    fwd;  // {fwd_a, fwd_b}
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [CW-1:0] sat(input int v);
    int m;
    m = (v > 15) ? 15 : v;
    return m[CW-1:0];
  endfunction

  task automatic step(input string nm, input logic rst, input logic iv,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic urs, input logic urt, input logic wr, input logic ld,
                      input logic [AW-1:0] dst, input logic jmp, input logic br,
                      input logic busy, input logic [3:0] ctl, input logic [1:0] fa,
                      input logic [1:0] fb, input logic [CW-1:0] sc, input logic [CW-1:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; id_valid = iv; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_regwr = wr; id_mem2reg = ld; id_dst = dst; id_jump = jmp;
    ex_br_taken = br; mem_busy = busy;
    e.nm = nm; e.ctl = ctl; e.fwd = {fa, fb}; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({pc_hold, ifid_hold, ifid_flush, idex_bubble} !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got=%b want=%b", e.nm,
                 {pc_hold, ifid_hold, ifid_flush, idex_bubble}, e.ctl);
      end
      checks++;
      if ({fwd_a, fwd_b} !== e.fwd) begin
        errors++;
        $display("FAIL %s fwd got=%b want=%b", e.nm, {fwd_a, fwd_b}, e.fwd);
      end
      checks++;
      if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        errors++;
        $display("FAIL %s cnt got=%0d/%0d want=%0d/%0d", e.nm,
                 stall_cnt, flush_cnt, e.sc, e.fc);
      end
    end
  end

  initial begin
    //    name          rst iv rs  rt urs urt wr ld dst jmp br busy ctl      fa     fb     sc fc
    step("reset",       0, 1, 8,  9, 1, 1, 1, 1, 8,  1, 0, 1, 4'b0000, 2'b00, 2'b00, 0, 0);
    step("lw8",         1, 1, 29, 0, 1, 0, 1, 1, 8,  0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0);
    step("lu_stall",    1, 1, 8,  9, 1, 1, 1, 0, 10, 0, 0, 0, 4'b1101, 2'b00, 2'b00, 0, 0);
    step("lu_fwd_mem",  1, 1, 8,  9, 1, 1, 1, 0, 10, 0, 0, 0, 4'b0000, 2'b10, 2'b00, 1, 0);
    step("fwd_ex",      1, 1, 12, 10,1, 1, 1, 0, 11, 0, 0, 0, 4'b0000, 2'b00, 2'b01, 1, 0);
    step("fwd_ex2",     1, 1, 11, 0, 1, 1, 1, 0, 11, 0, 0, 0, 4'b0000, 2'b01, 2'b00, 1, 0);
    step("ex_over_mem", 1, 1, 11, 10,1, 1, 1, 0, 12, 0, 0, 0, 4'b0000, 2'b01, 2'b11, 1, 0);
    step("lw20",        1, 1, 29, 0, 1, 0, 1, 1, 20, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 0);
    step("br_vs_lu",    1, 1, 20, 0, 1, 0, 1, 0, 21, 0, 1, 0, 4'b0011, 2'b00, 2'b00, 1, 0);
    step("after_br",    1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 1);
    step("jump",        1, 1, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 4'b0010, 2'b00, 2'b00, 1, 1);
    step("lw5",         1, 1, 29, 0, 1, 0, 1, 1, 5,  0, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 2);
    step("lu2_stall",   1, 1, 6,  5, 1, 1, 1, 0, 7,  0, 0, 0, 4'b1101, 2'b00, 2'b00, 1, 2);
    step("busy1",       1, 1, 6,  5, 1, 1, 1, 0, 7,  0, 0, 1, 4'b1100, 2'b00, 2'b10, 2, 2);
    step("busy2",       1, 1, 6,  5, 1, 1, 1, 0, 7,  0, 0, 1, 4'b1100, 2'b00, 2'b10, 2, 2);
    step("busy3",       1, 1, 6,  5, 1, 1, 1, 0, 7,  0, 0, 1, 4'b1100, 2'b00, 2'b10, 2, 2);
    step("release",     1, 1, 6,  5, 1, 1, 1, 0, 7,  0, 0, 0, 4'b0000, 2'b00, 2'b10, 2, 2);
    step("post_hold",   1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 2'b00, 2'b00, 2, 2);
    step("zero1",       1, 1, 0,  0, 1, 1, 1, 1, 0,  0, 0, 0, 4'b0000, 2'b00, 2'b00, 2, 2);
    step("zero2",       1, 1, 0,  0, 1, 1, 1, 1, 0,  0, 0, 0, 4'b0000, 2'b00, 2'b00, 2, 2);
    step("zero3",       1, 1, 0,  0, 1, 1, 1, 1, 0,  0, 0, 0, 4'b0000, 2'b00, 2'b00, 2, 2);
    step("zero_all",    1, 1, 0,  0, 1, 1, 1, 1, 0,  0, 0, 0, 4'b0000, 2'b00, 2'b00, 2, 2);
    // Repeated load-use pairs drive stall_cnt into saturation and one beyond.
    for (int i = 0; i < 14; i++) begin
      step("sat_lw",    1, 1, 29, 0, 1, 0, 1, 1, 3,  0, 0, 0, 4'b0000, 2'b00, 2'b00, sat(2+i), 2);
      step("sat_lu",    1, 1, 3,  0, 1, 0, 1, 0, 4,  0, 0, 0, 4'b1101, 2'b00, 2'b00, sat(2+i), 2);
      step("sat_fwd",   1, 1, 3,  0, 1, 0, 1, 0, 4,  0, 0, 0, 4'b0000, 2'b10, 2'b00, sat(3+i), 2);
    end
    for (int j = 0; j < 14; j++)
      step("sat_jmp",   1, 1, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 4'b0010, 2'b00, 2'b00, 15, sat(2+j));
    step("r_lw",        1, 1, 29, 0, 1, 0, 1, 1, 3,  0, 0, 0, 4'b0000, 2'b00, 2'b00, 15, 15);
    step("r_lu_sat",    1, 1, 3,  0, 1, 0, 1, 0, 4,  0, 0, 0, 4'b1101, 2'b00, 2'b00, 15, 15);
    step("r_busy",      1, 1, 3,  0, 1, 0, 1, 0, 4,  0, 0, 1, 4'b1100, 2'b10, 2'b00, 15, 15);
    step("rst_mid",     0, 1, 3,  0, 1, 0, 1, 0, 4,  1, 0, 1, 4'b0000, 2'b00, 2'b00, 0, 0);
    step("post_rst",    1, 1, 3,  0, 1, 0, 1, 0, 4,  0, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0);
    for (int k = 0; k < 4 && q.size() != 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter CW, default 16, performance-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 id_valid  in  1  decode stage holds a real instruction.
REQ-006 id_rs, id_rt  in  AW  decode source registers.
REQ-007 id_use_rs, id_use_rt  in  1  source actually read.
REQ-008 id_regwr, id_mem2reg  in  1  decode instruction writes a register / is a load.
REQ-009 id_dst  in  AW  decode destination (rd, rt or 31 already selected).
REQ-010 id_jump  in  1  decode holds j/jal/jr.
REQ-011 ex_br_taken  in  1  branch in EX resolved taken.
REQ-012 mem_busy  in  1  data memory not ready; whole pipe must hold.
REQ-013 pc_hold, ifid_hold  out  1  freeze PC / IF-ID register.
REQ-014 ifid_flush, idex_bubble  out  1  clear IF-ID / insert NOP into ID-EX.
REQ-015 fwd_a, fwd_b  out  2  operand source for rs / rt: 00 regfile, 01 EX ALU result, 10 MEM result, 11 WB data.
REQ-016 stall_cnt, flush_cnt  out  CW  saturating event counters.

Function
REQ-017 The block SHALL keep a shadow pipeline of three slots (EX, MEM, WB), each {valid, regwr, mem2reg, dst}.
REQ-018 When mem_busy=0 slots SHALL advance each cycle: WB<=MEM, MEM<=EX, EX<=decode (invalid if idex_bubble=1 or id_valid=0).
REQ-019 When mem_busy=1 all slots SHALL hold, pc_hold=ifid_hold=1, flush/bubble outputs 0.
REQ-020 Load-use hazard = id_valid, EX valid, EX regwr & mem2reg, EX dst!=0, and EX dst matches a used source.
REQ-021 Priority SHALL be mem_busy > ex_br_taken > load-use > id_jump.
REQ-022 ex_br_taken (mem_busy=0): ifid_flush=1, idex_bubble=1, pc_hold=0; load-use suppressed.
REQ-023 Load-use (no higher event): pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly one cycle; stall_cnt increments.
REQ-024 id_jump (no higher event): ifid_flush=1 for one cycle, no bubble.
REQ-025 flush_cnt SHALL increment once per cycle with ifid_flush=1; both counters saturate at all-ones.
REQ-026 FSM states RUN, LDSTALL, HOLD: RUN->LDSTALL on load-use; LDSTALL->RUN next cycle unconditionally (the hazard is cleared by the bubble); any->HOLD while mem_busy=1; HOLD->pre-hold state on mem_busy=0.
REQ-027 A load-use hazard SHALL NOT be reported twice for the same decode instruction (LDSTALL masks re-detection).
REQ-028 Forwarding select for each used source: nearest matching valid slot with regwr=1 and dst!=0 wins, EX(01) > MEM(10) > WB(11); else 00.
REQ-029 EX slot with mem2reg=1 SHALL never produce 01 (covered by stall).
REQ-030 Source register 0 or unused source SHALL yield 00.
REQ-031 All hazard/forward outputs SHALL be combinational from slots, state and inputs; zero added latency.

Reset
REQ-032 On rst_n=0 all slots invalid, FSM RUN, counters 0, all outputs 0, immediately and independent of clk.
REQ-033 Reset asserted during LDSTALL or HOLD SHALL discard the pending event; first cycle after release behaves as RUN with empty pipe.

Structure
REQ-034 A shared package hazard_pkg SHALL hold the fwd encoding constants and the FSM state type.
REQ-035 One sub-module, hz_slot_pipe (the three-slot shadow pipeline), SHALL be instantiated; the rest is flat.

Verification
REQ-036 lw $8 in EX, decode add uses rs=$8 -> one cycle pc_hold=ifid_hold=idex_bubble=1, then fwd_a=10, stall_cnt=1.
REQ-037 add $9 in EX, decode sub rt=$9 -> fwd_b=01, no stall; same dst in EX and MEM -> 01 chosen.
REQ-038 ex_br_taken=1 coincident with load-use -> ifid_flush=1, idex_bubble=1, pc_hold=0, stall_cnt unchanged, flush_cnt +1.
REQ-039 mem_busy=1 for 3 cycles during LDSTALL -> all hold, slots frozen; after release stall completes once, stall_cnt +1 only.
REQ-040 Decode writes/reads $0 with $0 dst in every slot -> fwd_a=fwd_b=00, no stall.
REQ-041 Force stall_cnt to 0xFFFF, trigger load-use -> remains 0xFFFF; rst_n low mid-stall -> all outputs 0 asynchronously.
